// File: rtl/ecal_acq_sequencer.sv
// Purpose : runs the ECAL ASIC chain through acquisition, conversion, readout
//           and hold-off, from a start pulse or continuously while run_en is high.
// Latency : start_acq/run_en sampled at edge N gives acq_o high from edge N+1.
//           All outputs come from registers.
// Backpressure : none. start_acq outside IDLE is dropped, and abort wins over
//           every other input.
// Ports   : clk/rst_n     clock, async active-low reset
//           start_acq     single-cycle start request (IDLE only)
//           run_en        level, re-arm automatically from IDLE
//           abort         return to IDLE on next edge
//           acq_window    ACQ length in cycles (0 treated as 1)
//           chip_sat/ext_stop  early ACQ terminators
//           end_readout   readout finished return from the ASIC chain
//           acq_o/conv_o/rd_start_o  ASIC control lines
//           busy/state_o/stop_reason/rd_timeout/cycle_cnt  status
module ecal_acq_sequencer #(
  parameter int CONV_CYCLES    = 4000,
  parameter int RD_TIMEOUT     = 65535,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_acq,
  input  logic        run_en,
  input  logic        abort,
  input  logic [15:0] acq_window,
  input  logic        chip_sat,
  input  logic        ext_stop,
  input  logic        end_readout,
  output logic        acq_o,
  output logic        conv_o,
  output logic        rd_start_o,
  output logic        busy,
  output logic [2:0]  state_o,
  output logic [1:0]  stop_reason,
  output logic        rd_timeout,
  output logic [15:0] cycle_cnt
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACQ     = 3'd1;
  localparam logic [2:0] ST_CONV    = 3'd2;
  localparam logic [2:0] ST_RDOUT   = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  localparam logic [15:0] CONV_LD = 16'(CONV_CYCLES);
  localparam logic [15:0] RD_LD   = 16'(RD_TIMEOUT);
  localparam logic [15:0] HO_LD   = 16'(HOLDOFF_CYCLES);

  logic [2:0]  state_q, state_d;
  // One down-counter shared by every timed phase; each phase loads its own
  // length on entry and leaves when the count reaches 1.
  logic [15:0] tmr_q, tmr_d;
  logic [1:0]  stop_q, stop_d;
  logic        tmo_q, tmo_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic        rd_start_q, rd_start_d;
  // Holds the FSM for one edge after reset release, so the first transition
  // can only happen on the second edge.
  logic        armed_q;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    stop_d      = stop_q;
    tmo_d       = tmo_q;
    cycle_cnt_d = cycle_cnt_q;
    rd_start_d  = 1'b0;

    if (!armed_q) begin
      state_d = ST_IDLE;
    end else if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_acq || run_en) begin
            state_d = ST_ACQ;
            tmr_d   = (acq_window == 16'd0) ? 16'd1 : acq_window;
            tmo_d   = 1'b0;
          end
        end
        ST_ACQ: begin
          // chip_sat outranks ext_stop, which outranks window expiry
          if (chip_sat || ext_stop || tmr_q == 16'd1) begin
            state_d = ST_CONV;
            tmr_d   = CONV_LD;
            if (chip_sat)      stop_d = 2'd1;
            else if (ext_stop) stop_d = 2'd2;
            else               stop_d = 2'd0;
          end else begin
            tmr_d = tmr_q - 16'd1;
          end
        end
        ST_CONV: begin
          if (tmr_q == 16'd1) begin
            state_d    = ST_RDOUT;
            tmr_d      = RD_LD;
            rd_start_d = 1'b1;
          end else begin
            tmr_d = tmr_q - 16'd1;
          end
        end
        ST_RDOUT: begin
          if (end_readout || tmr_q == 16'd1) begin
            state_d     = ST_HOLDOFF;
            tmr_d       = HO_LD;
            cycle_cnt_d = cycle_cnt_q + 16'd1;
            if (!end_readout) tmo_d = 1'b1;
          end else begin
            tmr_d = tmr_q - 16'd1;
          end
        end
        ST_HOLDOFF: begin
          if (tmr_q == 16'd1) state_d = ST_IDLE;
          else                tmr_d   = tmr_q - 16'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= 16'd0;
      stop_q      <= 2'd0;
      tmo_q       <= 1'b0;
      cycle_cnt_q <= 16'd0;
      rd_start_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      stop_q      <= stop_d;
      tmo_q       <= tmo_d;
      cycle_cnt_q <= cycle_cnt_d;
      rd_start_q  <= rd_start_d;
      armed_q     <= 1'b1;
    end
  end

  assign acq_o       = (state_q == ST_ACQ);
  assign conv_o      = (state_q == ST_CONV);
  assign busy        = (state_q != ST_IDLE);
  assign rd_start_o  = rd_start_q;
  assign state_o     = state_q;
  assign stop_reason = stop_q;
  assign rd_timeout  = tmo_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_ecal_acq_sequencer.sv
// Purpose : directed checks of the ECAL acquisition sequencer.
// Latency : n/a (bench).
// Backpressure : n/a (bench).
module tb_ecal_acq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_acq, run_en, abort;
  logic [15:0] acq_window;
  logic        chip_sat, ext_stop, end_readout;
  logic        acq_o, conv_o, rd_start_o, busy;
  logic [2:0]  state_o;
  logic [1:0]  stop_reason;
  logic        rd_timeout;
  logic [15:0] cycle_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Free-running output-high counters, sampled mid-cycle.
  int acq_n = 0, conv_n = 0, rd_n = 0;

  ecal_acq_sequencer #(
    .CONV_CYCLES(8), .RD_TIMEOUT(20), .HOLDOFF_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_acq(start_acq), .run_en(run_en),
    .abort(abort), .acq_window(acq_window), .chip_sat(chip_sat),
    .ext_stop(ext_stop), .end_readout(end_readout), .acq_o(acq_o),
    .conv_o(conv_o), .rd_start_o(rd_start_o), .busy(busy),
    .state_o(state_o), .stop_reason(stop_reason), .rd_timeout(rd_timeout),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    if (acq_o)      acq_n  = acq_n + 1;
    if (conv_o)     conv_n = conv_n + 1;
    if (rd_start_o) rd_n   = rd_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_acq = 1'b1;
    step();
    start_acq = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state_o !== s && n < budget) begin
      step();
      n++;
    end
    chk(tag, state_o, s);
  endtask

  int a0, c0, r0, n, idles;
  logic [2:0] st [1:46];

  initial begin
    rst_n = 1'b0; start_acq = 0; run_en = 0; abort = 0; acq_window = 16'd10;
    chip_sat = 0; ext_stop = 0; end_readout = 0;

    // Reset state and reset release timing
    step(); step();
    chk("rst_state", state_o, 0);
    chk("rst_outs", {acq_o, conv_o, rd_start_o, busy, rd_timeout}, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_reason", stop_reason, 0);
    rst_n = 1'b1; start_acq = 1'b1;
    step();
    chk("rel_edge1", state_o, 0);
    step();
    chk("rel_edge2", state_o, 1);
    start_acq = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("rel_abort", state_o, 0);

    // Single shot, window 10
    a0 = acq_n; c0 = conv_n; r0 = rd_n;
    acq_window = 16'd10;
    pulse_start();
    chk("t1_acq_entry", state_o, 1);
    n = 0;
    while (!rd_start_o && n < 100) begin step(); n++; end
    chk("t1_rd_seen", rd_start_o, 1);
    chk("t1_acq_len", acq_n - a0, 10);
    chk("t1_conv_len", conv_n - c0, 8);
    chk("t1_rd_pulses", rd_n - r0, 1);
    repeat (4) step();
    chk("t1_still_rd", state_o, 3);
    end_readout = 1'b1;
    step();
    end_readout = 1'b0;
    chk("t1_holdoff", state_o, 4);
    chk("t1_cnt", cycle_cnt, 1);
    repeat (3) step();
    chk("t1_ho_len", state_o, 4);
    step();
    chk("t1_idle", state_o, 0);
    chk("t1_busy", busy, 0);
    chk("t1_reason", stop_reason, 0);
    chk("t1_rd_once", rd_n - r0, 1);

    // chip_sat and ext_stop together on ACQ cycle 3; end_readout held early
    acq_window = 16'd100;
    pulse_start();
    chk("t2_acq1", state_o, 1);
    step(); step();
    chip_sat = 1'b1; ext_stop = 1'b1; end_readout = 1'b1;
    c0 = conv_n;
    step();
    chip_sat = 1'b0; ext_stop = 1'b0;
    chk("t2_acq_fell", acq_o, 0);
    chk("t2_conv_rose", conv_o, 1);
    chk("t2_reason", stop_reason, 1);
    wait_state(3, 50, "t2_to_rd");
    chk("t2_conv_len", conv_n - c0, 8);
    step();
    chk("t2_holdoff", state_o, 4);
    chk("t2_cnt", cycle_cnt, 2);
    end_readout = 1'b0;
    wait_state(0, 20, "t2_idle");

    // Readout timeout
    acq_window = 16'd2;
    pulse_start();
    wait_state(3, 50, "t3_to_rd");
    n = 0;
    while (state_o == 3'd3 && n < 100) begin step(); n++; end
    chk("t3_rd_len", n, 20);
    chk("t3_state", state_o, 4);
    chk("t3_tmo", rd_timeout, 1);
    chk("t3_cnt", cycle_cnt, 3);
    wait_state(0, 20, "t3_idle");
    chk("t3_tmo_sticky", rd_timeout, 1);
    pulse_start();
    chk("t3_restart", state_o, 1);
    chk("t3_tmo_clr", rd_timeout, 0);

    // Abort in CONV; abort held keeps IDLE
    wait_state(2, 20, "t4_to_conv");
    abort = 1'b1;
    step();
    chk("t4_abort_state", state_o, 0);
    chk("t4_abort_outs", {acq_o, conv_o, busy}, 0);
    chk("t4_abort_cnt", cycle_cnt, 3);
    chk("t4_abort_reason", stop_reason, 0);
    start_acq = 1'b1;
    step();
    chk("t4_abort_hold", state_o, 0);
    abort = 1'b0; start_acq = 1'b0;
    step();
    chk("t4_after", state_o, 0);

    // Continuous run, window 0 -> 1-cycle ACQ, readout returns immediately
    acq_window = 16'd0; end_readout = 1'b1;
    a0 = acq_n;
    run_en = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      step();
      st[k] = state_o;
      if (k == 44) run_en = 1'b0;
    end
    idles = 0;
    for (int k = 1; k <= 44; k++) if (st[k] == 3'd0) idles++;
    chk("t5_k1_acq", st[1], 1);
    chk("t5_k2_conv", st[2], 2);
    chk("t5_k10_rd", st[10], 3);
    chk("t5_k11_ho", st[11], 4);
    chk("t5_k15_idle", st[15], 0);
    chk("t5_k16_acq", st[16], 1);
    chk("t5_idle_cnt", idles, 2);
    chk("t5_k45_idle", st[45], 0);
    chk("t5_k46_stop", st[46], 0);
    chk("t5_acq_len", acq_n - a0, 3);
    chk("t5_cnt", cycle_cnt, 6);
    end_readout = 1'b0;

    // ext_stop alone, and cycle counter wrap
    acq_window = 16'd50;
    pulse_start();
    chk("t6_acq", state_o, 1);
    force dut.cycle_cnt_q = 16'hFFFF;
    ext_stop = 1'b1;
    step();
    ext_stop = 1'b0;
    release dut.cycle_cnt_q;
    chk("t6_reason", stop_reason, 2);
    chk("t6_preload", cycle_cnt, 16'hFFFF);
    end_readout = 1'b1;
    wait_state(4, 30, "t6_to_ho");
    chk("t6_wrap", cycle_cnt, 0);
    end_readout = 1'b0;
    wait_state(0, 20, "t6_idle");

    // Reset in RDOUT
    acq_window = 16'd1;
    pulse_start();
    wait_state(3, 30, "t7_to_rd");
    chk("t7_rd_pulse", rd_start_o, 1);
    rst_n = 1'b0;
    #1;
    chk("t7_state", state_o, 0);
    chk("t7_outs", {acq_o, conv_o, rd_start_o, busy, rd_timeout}, 0);
    chk("t7_cnt", cycle_cnt, 0);
    step();
    rst_n = 1'b1;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ecal_acq_sequencer.md
# ecal_acq_sequencer

Sequences the ECAL front-end ASIC chain on the DIF through one complete cycle: acquisition window, analogue-to-digital conversion, serial readout, hold-off. It drives the ASIC start_acquisition, start_conversion and start_readout lines, and watches the ASIC chip_sat and end_readout returns. It sits between the DIF slow-control/run registers and the ASIC pins. Single-shot cycles come from a start pulse; continuous cycles run while `run_en` is high.

## Interface
- `CONV_CYCLES`, 4000: conversion phase length in `clk` cycles (≥2).
- `RD_TIMEOUT`, 65535: maximum `clk` cycles spent waiting for `end_readout`.
- `HOLDOFF_CYCLES`, 16: idle gap after readout before re-arm (≥1).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_acq` in 1: single-cycle pulse; requests one cycle when in IDLE.
- `run_en` in 1: level; while high, a new cycle starts automatically from IDLE.
- `abort` in 1: level/pulse; forces IDLE from any state.
- `acq_window` in 16: acquisition length in cycles, sampled on IDLE→ACQ; 0 is treated as 1.
- `chip_sat` in 1: ASIC memory full; ends ACQ early (synchronous to `clk`).
- `ext_stop` in 1: external stop; ends ACQ early.
- `end_readout` in 1: ASIC chain readout finished (level or pulse).
- `acq_o` out 1: ASIC start_acquisition, high throughout ACQ.
- `conv_o` out 1: ASIC start_conversion, high throughout CONV.
- `rd_start_o` out 1: one-cycle pulse on CONV→RDOUT.
- `busy` out 1: high in every state except IDLE.
- `state_o` out 3: IDLE=0, ACQ=1, CONV=2, RDOUT=3, HOLDOFF=4.
- `stop_reason` out 2: 0 window expired, 1 chip_sat, 2 ext_stop; latched at ACQ exit.
- `rd_timeout` out 1: sticky; set when RDOUT times out, cleared on the next IDLE→ACQ.
- `cycle_cnt` out 16: number of completed cycles (entries into HOLDOFF); wraps 0xFFFF→0.

## Operation
- Reset: state IDLE; all outputs 0, `cycle_cnt`=0, `stop_reason`=0.
- IDLE: `start_acq` or `run_en` → ACQ. Load the window counter with max(`acq_window`,1). Clear `rd_timeout`.
- ACQ: the window counter decrements every cycle. Exit to CONV when either (a) the counter equals 1, or (b) `chip_sat` or `ext_stop` is high.
- Stop-reason priority on simultaneous events: chip_sat > ext_stop > window.
- CONV: runs for exactly `CONV_CYCLES` cycles, then → RDOUT.
- RDOUT: → HOLDOFF when `end_readout` is high. If `end_readout` is not seen within `RD_TIMEOUT` cycles, set `rd_timeout` and → HOLDOFF.
- `end_readout` asserted before RDOUT is ignored.
- HOLDOFF: `cycle_cnt` increments on entry, including on a timeout exit. After `HOLDOFF_CYCLES` cycles → IDLE.
- `abort` high: from any state, → IDLE on the next edge. `acq_o`, `conv_o` and `busy` are 0 that cycle. `cycle_cnt` and `stop_reason` are not updated. While `abort` is held, IDLE does not leave.
- `start_acq` outside IDLE is ignored; it is not queued.
- Dropping `run_en` mid-cycle does not end the current cycle; it only stops the next re-arm.

## Timing
- All outputs are registered and decoded from the state register.
- `start_acq` at edge N → `acq_o`=1 from edge N+1.
- With `acq_window`=W and no early stop, `acq_o` is high exactly W cycles.
- Early stop: `chip_sat` sampled high at edge M → `acq_o` low and `conv_o` high from edge M+1.
- `conv_o` is high exactly `CONV_CYCLES` cycles. `rd_start_o` pulses in the first RDOUT cycle.
- `end_readout` sampled at edge R → HOLDOFF from R+1, with `cycle_cnt` updated at R+1.
- Timeout: after `RD_TIMEOUT` RDOUT cycles without `end_readout`.
- With `run_en` held, back-to-back period = W + `CONV_CYCLES` + readout + `HOLDOFF_CYCLES` + 1 (IDLE cycle).
- `rst_n` low clears everything asynchronously. Release is synchronous to `clk`; the first transition is possible on the second edge after release.

## Test plan
- Single shot, `acq_window`=10, `CONV_CYCLES`=8, `end_readout` 5 cycles after `rd_start_o`:
  - `acq_o` high 10 cycles, `conv_o` high 8 cycles, one `rd_start_o` pulse.
  - Afterwards `cycle_cnt`=1, `stop_reason`=0, `busy` low after HOLDOFF.
- `chip_sat` and `ext_stop` both high on ACQ cycle 3 of 100 → `acq_o` falls next edge, `stop_reason`=1.
- `end_readout` never arrives, `RD_TIMEOUT`=20 → HOLDOFF after 20 RDOUT cycles, `rd_timeout`=1, `cycle_cnt` increments. Next cycle start clears `rd_timeout`.
- `run_en` held for 3 cycles' worth of time → `cycle_cnt`=3, IDLE lasts exactly 1 cycle between cycles. `acq_window`=0 gives a 1-cycle ACQ.
- `abort` pulsed in CONV, and separately `rst_n` asserted in RDOUT → IDLE with all outputs 0. `cycle_cnt` is unchanged for abort and 0 for reset.
- Preload `cycle_cnt` to 0xFFFF via repeated cycles or force, run one cycle → `cycle_cnt`=0x0000.
